// File: rtl/ram_bank_scheduler.sv
// Bank ring scheduler for the raw/OTP RAM pairs shared by the SD
// raw-fill, OTP-fill and writeback clients.
//
// Ports:
//   iclk, irst              clock, async active-high reset
//   iflush                  sync abort of all flags, pointers, owners
//   i*_req / o*_gnt         level request, one-cycle grant pulse
//   o*_bank                 bank owned by the client (held after release)
//   i*_done                 one-cycle release pulse from the owner
//   oready                  per-bank raw_valid & otp_valid
//   oempty                  no flag set and no owner active
module ram_bank_scheduler #(
    parameter int NBANKS = 8,
    parameter int BANK_W = 3
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              iflush,
    input  logic              iraw_req,
    output logic              oraw_gnt,
    output logic [BANK_W-1:0] oraw_bank,
    input  logic              iraw_done,
    input  logic              iotp_req,
    output logic              ootp_gnt,
    output logic [BANK_W-1:0] ootp_bank,
    input  logic              iotp_done,
    input  logic              iwb_req,
    output logic              owb_gnt,
    output logic [BANK_W-1:0] owb_bank,
    input  logic              iwb_done,
    output logic [NBANKS-1:0] oready,
    output logic              oempty
);

    typedef enum logic {S_IDLE, S_OWN} own_e;

    own_e              raw_st_q, raw_st_d;
    own_e              otp_st_q, otp_st_d;
    own_e              wb_st_q, wb_st_d;
    logic [NBANKS-1:0] raw_vld_q, raw_vld_d;
    logic [NBANKS-1:0] otp_vld_q, otp_vld_d;
    logic [BANK_W-1:0] raw_ptr_q, raw_ptr_d;
    logic [BANK_W-1:0] otp_ptr_q, otp_ptr_d;
    logic [BANK_W-1:0] wb_ptr_q, wb_ptr_d;
    logic [BANK_W-1:0] raw_bank_q, raw_bank_d;
    logic [BANK_W-1:0] otp_bank_q, otp_bank_d;
    logic [BANK_W-1:0] wb_bank_q, wb_bank_d;
    logic              raw_gnt_q, raw_gnt_d;
    logic              otp_gnt_q, otp_gnt_d;
    logic              wb_gnt_q, wb_gnt_d;
    logic [NBANKS-1:0] ready_q, ready_d;
    logic              empty_q, empty_d;

    logic raw_ok, otp_ok, wb_ok;
    logic raw_take, otp_take, wb_take;
    logic raw_rel, otp_rel, wb_rel;
    logic wb_own;

    // Grant checks always look at the pre-edge flags, so a flag set or
    // cleared in this cycle affects the other clients one cycle later.
    assign wb_own = (wb_st_q == S_OWN);
    assign raw_ok = !raw_vld_q[raw_ptr_q]
                  && !(wb_own && wb_bank_q == raw_ptr_q);
    assign otp_ok = !otp_vld_q[otp_ptr_q]
                  && !(wb_own && wb_bank_q == otp_ptr_q);
    assign wb_ok  = raw_vld_q[wb_ptr_q] && otp_vld_q[wb_ptr_q];

    assign raw_take = !iflush && raw_st_q == S_IDLE && iraw_req && raw_ok;
    assign otp_take = !iflush && otp_st_q == S_IDLE && iotp_req && otp_ok;
    assign wb_take  = !iflush && wb_st_q == S_IDLE && iwb_req && wb_ok;
    assign raw_rel  = !iflush && raw_st_q == S_OWN && iraw_done;
    assign otp_rel  = !iflush && otp_st_q == S_OWN && iotp_done;
    assign wb_rel   = !iflush && wb_st_q == S_OWN && iwb_done;

    // State register
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            raw_st_q   <= S_IDLE;
            otp_st_q   <= S_IDLE;
            wb_st_q    <= S_IDLE;
            raw_vld_q  <= '0;
            otp_vld_q  <= '0;
            raw_ptr_q  <= '0;
            otp_ptr_q  <= '0;
            wb_ptr_q   <= '0;
            raw_bank_q <= '0;
            otp_bank_q <= '0;
            wb_bank_q  <= '0;
            raw_gnt_q  <= 1'b0;
            otp_gnt_q  <= 1'b0;
            wb_gnt_q   <= 1'b0;
            ready_q    <= '0;
            empty_q    <= 1'b1;
        end else begin
            raw_st_q   <= raw_st_d;
            otp_st_q   <= otp_st_d;
            wb_st_q    <= wb_st_d;
            raw_vld_q  <= raw_vld_d;
            otp_vld_q  <= otp_vld_d;
            raw_ptr_q  <= raw_ptr_d;
            otp_ptr_q  <= otp_ptr_d;
            wb_ptr_q   <= wb_ptr_d;
            raw_bank_q <= raw_bank_d;
            otp_bank_q <= otp_bank_d;
            wb_bank_q  <= wb_bank_d;
            raw_gnt_q  <= raw_gnt_d;
            otp_gnt_q  <= otp_gnt_d;
            wb_gnt_q   <= wb_gnt_d;
            ready_q    <= ready_d;
            empty_q    <= empty_d;
        end
    end

    // Next-state logic for the three owner FSMs
    always_comb begin
        raw_st_d = raw_st_q;
        otp_st_d = otp_st_q;
        wb_st_d  = wb_st_q;
        if (iflush) begin
            raw_st_d = S_IDLE;
            otp_st_d = S_IDLE;
            wb_st_d  = S_IDLE;
        end else begin
            if (raw_take) raw_st_d = S_OWN;
            if (raw_rel)  raw_st_d = S_IDLE;
            if (otp_take) otp_st_d = S_OWN;
            if (otp_rel)  otp_st_d = S_IDLE;
            if (wb_take)  wb_st_d  = S_OWN;
            if (wb_rel)   wb_st_d  = S_IDLE;
        end
    end

    // Outputs, flags and pointers
    always_comb begin
        raw_vld_d  = raw_vld_q;
        otp_vld_d  = otp_vld_q;
        raw_ptr_d  = raw_ptr_q;
        otp_ptr_d  = otp_ptr_q;
        wb_ptr_d   = wb_ptr_q;
        raw_bank_d = raw_bank_q;
        otp_bank_d = otp_bank_q;
        wb_bank_d  = wb_bank_q;
        raw_gnt_d  = raw_take;
        otp_gnt_d  = otp_take;
        wb_gnt_d   = wb_take;
        if (iflush) begin
            raw_vld_d  = '0;
            otp_vld_d  = '0;
            raw_ptr_d  = '0;
            otp_ptr_d  = '0;
            wb_ptr_d   = '0;
            raw_bank_d = '0;
            otp_bank_d = '0;
            wb_bank_d  = '0;
        end else begin
            if (raw_take) raw_bank_d = raw_ptr_q;
            if (otp_take) otp_bank_d = otp_ptr_q;
            if (wb_take)  wb_bank_d  = wb_ptr_q;
            if (raw_rel) begin
                raw_vld_d[raw_bank_q] = 1'b1;
                raw_ptr_d = raw_ptr_q + BANK_W'(1);
            end
            if (otp_rel) begin
                otp_vld_d[otp_bank_q] = 1'b1;
                otp_ptr_d = otp_ptr_q + BANK_W'(1);
            end
            // The wb-owned bank is never owned by a fill client, so the
            // clear cannot collide with a set above.
            if (wb_rel) begin
                raw_vld_d[wb_bank_q] = 1'b0;
                otp_vld_d[wb_bank_q] = 1'b0;
                wb_ptr_d = wb_ptr_q + BANK_W'(1);
            end
        end
        ready_d = raw_vld_d & otp_vld_d;
        empty_d = (raw_vld_d == '0) && (otp_vld_d == '0)
                && raw_st_d == S_IDLE && otp_st_d == S_IDLE
                && wb_st_d == S_IDLE;
    end

    assign oraw_gnt  = raw_gnt_q;
    assign ootp_gnt  = otp_gnt_q;
    assign owb_gnt   = wb_gnt_q;
    assign oraw_bank = raw_bank_q;
    assign ootp_bank = otp_bank_q;
    assign owb_bank  = wb_bank_q;
    assign oready    = ready_q;
    assign oempty    = empty_q;

endmodule

// File: tb/tb_ram_bank_scheduler.sv
// Directed-vector bench for ram_bank_scheduler.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ram_bank_scheduler;

    logic       iclk = 1'b0;
    logic       irst = 1'b1;
    logic       iflush = 1'b0;
    logic       iraw_req = 1'b0, iraw_done = 1'b0, oraw_gnt;
    logic       iotp_req = 1'b0, iotp_done = 1'b0, ootp_gnt;
    logic       iwb_req = 1'b0, iwb_done = 1'b0, owb_gnt;
    logic [2:0] oraw_bank, ootp_bank, owb_bank;
    logic [7:0] oready;
    logic       oempty;

    int nvec = 0;
    int nmis = 0;

    ram_bank_scheduler #(.NBANKS(8), .BANK_W(3)) dut (
        .iclk(iclk), .irst(irst), .iflush(iflush),
        .iraw_req(iraw_req), .oraw_gnt(oraw_gnt),
        .oraw_bank(oraw_bank), .iraw_done(iraw_done),
        .iotp_req(iotp_req), .ootp_gnt(ootp_gnt),
        .ootp_bank(ootp_bank), .iotp_done(iotp_done),
        .iwb_req(iwb_req), .owb_gnt(owb_gnt),
        .owb_bank(owb_bank), .iwb_done(iwb_done),
        .oready(oready), .oempty(oempty)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic flush();
        iflush = 1'b1;
        step();
        iflush = 1'b0;
    endtask

    // Grant raw+OTP on bank b, then release both.
    task automatic fill_both(input logic [2:0] b);
        iraw_req = 1'b1;
        iotp_req = 1'b1;
        step();
        chk("fill_raw_gnt", oraw_gnt, 1);
        chk("fill_otp_gnt", ootp_gnt, 1);
        chk("fill_raw_bank", oraw_bank, b);
        chk("fill_otp_bank", ootp_bank, b);
        iraw_req  = 1'b0;
        iotp_req  = 1'b0;
        iraw_done = 1'b1;
        iotp_done = 1'b1;
        step();
        iraw_done = 1'b0;
        iotp_done = 1'b0;
    endtask

    task automatic drain(input logic [2:0] b);
        iwb_req = 1'b1;
        step();
        chk("drain_gnt", owb_gnt, 1);
        chk("drain_bank", owb_bank, b);
        iwb_req  = 1'b0;
        iwb_done = 1'b1;
        step();
        iwb_done = 1'b0;
    endtask

    initial begin
        logic seen;

        // Reset with both fill requests held
        iraw_req = 1'b1;
        iotp_req = 1'b1;
        step();
        step();
        chk("rst_ready", oready, 8'h00);
        chk("rst_empty", oempty, 1);
        chk("rst_rgnt", oraw_gnt, 0);
        chk("rst_wbank", owb_bank, 0);
        irst = 1'b0;
        step();
        chk("t1_rgnt", oraw_gnt, 1);
        chk("t1_ogtn", ootp_gnt, 1);
        chk("t1_rbank", oraw_bank, 0);
        chk("t1_obank", ootp_bank, 0);
        chk("t1_empty", oempty, 0);
        iraw_req  = 1'b0;
        iotp_req  = 1'b0;
        iraw_done = 1'b1;
        iotp_done = 1'b1;
        step();
        iraw_done = 1'b0;
        iotp_done = 1'b0;
        chk("t1_ready", oready, 8'h01);
        chk("t1_rgnt_pulse", oraw_gnt, 0);
        iwb_req = 1'b1;
        step();
        chk("t1_wgnt", owb_gnt, 1);
        chk("t1_wbank", owb_bank, 0);
        iwb_req  = 1'b0;
        iwb_done = 1'b1;
        step();
        iwb_done = 1'b0;
        chk("t1_ready_clr", oready, 8'h00);
        chk("t1_empty_end", oempty, 1);
        flush();

        // Fill all eight banks, then overflow
        for (int i = 0; i < 8; i++) fill_both(3'(i));
        chk("t2_ready_full", oready, 8'hFF);
        iraw_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | oraw_gnt;
        end
        chk("t2_full_stall", seen, 0);
        iwb_req = 1'b1;
        step();
        chk("t2_wgnt", owb_gnt, 1);
        chk("t2_wbank", owb_bank, 0);
        chk("t2_rgnt_wbown", oraw_gnt, 0);
        iwb_req  = 1'b0;
        iwb_done = 1'b1;
        step();
        iwb_done = 1'b0;
        chk("t2_rgnt_early", oraw_gnt, 0);
        chk("t2_ready_fe", oready, 8'hFE);
        step();
        chk("t2_rgnt_wrap", oraw_gnt, 1);
        chk("t2_rbank_wrap", oraw_bank, 0);
        iraw_req = 1'b0;
        flush();

        // Done pulses while idle are ignored
        iraw_done = 1'b1;
        iotp_done = 1'b1;
        step();
        iraw_done = 1'b0;
        iotp_done = 1'b0;
        chk("t3_ready", oready, 8'h00);
        chk("t3_empty", oempty, 1);
        chk("t3_rbank", oraw_bank, 0);
        fill_both(3'd0);
        chk("t3_ready_after", oready, 8'h01);
        flush();

        // Raw done on bank 3 together with wb request
        for (int i = 0; i < 3; i++) fill_both(3'(i));
        for (int i = 0; i < 3; i++) drain(3'(i));
        iotp_req = 1'b1;
        step();
        chk("t4_obank", ootp_bank, 3);
        iotp_req  = 1'b0;
        iotp_done = 1'b1;
        step();
        iotp_done = 1'b0;
        iraw_req = 1'b1;
        step();
        chk("t4_rbank", oraw_bank, 3);
        iraw_req  = 1'b0;
        iraw_done = 1'b1;
        iwb_req   = 1'b1;
        step();
        iraw_done = 1'b0;
        chk("t4_wgnt_early", owb_gnt, 0);
        chk("t4_ready", oready, 8'h08);
        step();
        chk("t4_wgnt", owb_gnt, 1);
        chk("t4_wbank", owb_bank, 3);
        iwb_req = 1'b0;

        // Flush with all three clients owning
        iraw_req = 1'b1;
        iotp_req = 1'b1;
        step();
        chk("t5_rbank", oraw_bank, 4);
        iraw_req  = 1'b0;
        iotp_req  = 1'b0;
        iflush    = 1'b1;
        iraw_done = 1'b1;
        iwb_req   = 1'b1;
        step();
        iflush    = 1'b0;
        iraw_done = 1'b0;
        chk("t5_ready", oready, 8'h00);
        chk("t5_empty", oempty, 1);
        chk("t5_rbank0", oraw_bank, 0);
        chk("t5_obank0", ootp_bank, 0);
        chk("t5_wbank0", owb_bank, 0);
        iraw_req = 1'b1;
        iotp_req = 1'b1;
        step();
        chk("t5_rgnt", oraw_gnt, 1);
        chk("t5_rbank", oraw_bank, 0);
        chk("t5_obank", ootp_bank, 0);
        chk("t5_wgnt", owb_gnt, 0);
        iraw_req  = 1'b0;
        iotp_req  = 1'b0;
        iwb_req   = 1'b0;

        // Async reset in the middle of a cycle during ownership
        iraw_done = 1'b1;
        iotp_done = 1'b1;
        step();
        iraw_done = 1'b0;
        iotp_done = 1'b0;
        iraw_req  = 1'b1;
        step();
        chk("t6_rbank", oraw_bank, 1);
        iraw_req = 1'b0;
        step();
        chk("t6_ready_pre", oready, 8'h01);
        #2;
        irst = 1'b1;
        #1;
        chk("t6_ready_async", oready, 8'h00);
        chk("t6_empty_async", oempty, 1);
        chk("t6_rbank_async", oraw_bank, 0);
        #1;
        irst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | oraw_gnt | ootp_gnt | owb_gnt;
        end
        chk("t6_no_gnt", seen, 0);
        iraw_req = 1'b1;
        step();
        chk("t6_rgnt", oraw_gnt, 1);
        chk("t6_rbank_new", oraw_bank, 0);
        iraw_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/ram_bank_scheduler.md
Name: ram_bank_scheduler

Overview:
- Sequences the eight raw/OTP 4-bit RAM bank pairs (1024 nibbles each, one 512-byte SD block per bank) between three clients.
- Clients:
  - Raw fill: the SD controller writes a block read from the card into the raw RAM.
  - OTP fill: the OTP generator writes keystream into the OTP RAM.
  - Writeback: the SD controller reads raw XOR OTP and writes the result back to the card.
- The block hands out bank indices in ring order, tracks per-bank fill flags, and stops any client from reusing a bank before the previous stage has consumed it.
- Drives the sel_ram/sel_ram_otp selects in place of fixed bank counting in the SD and OTP paths.

Parameters:
- NBANKS, 8, number of bank pairs; must be a power of two, 2..16.
- BANK_W, 3, bank index width; equals log2(NBANKS).

Ports:
- iclk  input  1  clock; the SD clock domain.
- irst  input  1  asynchronous reset, active-high.
- iflush  input  1  synchronous abort: clears all flags, pointers and ownership.
- iraw_req  input  1  raw-fill client requests a bank (level).
- oraw_gnt  output  1  one-cycle pulse: grant issued.
- oraw_bank  output  BANK_W  bank owned by the raw client; valid from oraw_gnt until iraw_done.
- iraw_done  input  1  one-cycle pulse: raw fill of the owned bank is complete.
- iotp_req, ootp_gnt, ootp_bank, iotp_done: same roles for the OTP client.
- iwb_req, owb_gnt, owb_bank, iwb_done: same roles for the writeback client.
- oready  output  NBANKS  per-bank flag: raw_valid AND otp_valid.
- oempty  output  1  high when no flag is set and no client owns a bank.

Behaviour:
- Reset (irst asynchronous) and iflush (synchronous) have the same effect:
  - all raw_valid and otp_valid flags = 0;
  - raw_ptr = otp_ptr = wb_ptr = 0;
  - all owners idle;
  - all gnt outputs = 0, all bank outputs = 0, oready = 0, oempty = 1.
  - iflush has priority over every req and done in the same cycle.
- Each client has its own 2-state FSM, IDLE and OWN.
- IDLE -> OWN when req=1 at a rising edge and the grant condition holds at that edge:
  - gnt pulses high for exactly that one following cycle;
  - bank output = the client's pointer;
  - latency from req to gnt is 1 cycle minimum.
- Grant conditions:
  - raw: raw_valid[raw_ptr]=0, and the writeback client does not own raw_ptr.
  - otp: otp_valid[otp_ptr]=0, and the writeback client does not own otp_ptr.
  - wb: raw_valid[wb_ptr]=1 and otp_valid[wb_ptr]=1.
- OWN -> IDLE on a done pulse:
  - raw done: set raw_valid[owned bank], raw_ptr <= raw_ptr+1.
  - otp done: set otp_valid[owned bank], otp_ptr <= otp_ptr+1.
  - wb done: clear both flags of the owned bank, wb_ptr <= wb_ptr+1.
  - Pointers wrap modulo NBANKS, e.g. 7 -> 0.
- Bank output holds the owned index through OWN and keeps that value after release until the next grant.
- A done pulse while IDLE is ignored: no flag or pointer change.
- req is ignored while in OWN. A client may hold req high across done; its next grant comes no earlier than the cycle after done is sampled.
- Raw and OTP clients may own the same bank at the same time (separate RAM arrays), and may be granted in the same cycle.
- Full condition: raw_valid[raw_ptr]=1. The raw client is stalled until the writeback client frees that bank. The same rule applies to OTP.
- Empty condition: the wb client is stalled while either flag of wb_ptr is 0.
- Simultaneous events in one cycle:
  - raw done setting raw_valid[b] together with a wb grant check on b: the check uses the pre-edge flag value, so the wb grant comes one cycle later.
  - wb done clearing bank b together with raw req for b: the raw grant is evaluated against pre-edge flags, so it issues on the next cycle.
- oready and oempty are registered values reflecting the current flags and owner states; they carry no extra latency beyond the flag update.
- Design size: about 200 lines of RTL, no memories, all state in flops.

Test Plan:
- Reset with iraw_req=iotp_req=1 held -> one cycle after irst deasserts: oraw_gnt=ootp_gnt=1, both banks=0; pulse both dones -> oready=8'h01 next cycle, then owb_gnt with owb_bank=0 one cycle after iwb_req.
- Fill all 8 banks (raw and OTP) with no writeback -> oready=8'hFF; a 9th raw req stays ungranted; wb done on bank 0 -> raw grant of bank 0 (wrapped pointer) two cycles later.
- iraw_done and iotp_done pulsed while IDLE -> no change to oready, pointers or bank outputs.
- Raw done on bank 3 and iwb_req in the same cycle with otp_valid[3]=1 -> owb_gnt one cycle after the raw flag sets, owb_bank=3.
- iflush asserted while all three clients are in OWN with mixed flags -> next cycle: oready=0, oempty=1, all bank outputs=0; subsequent grants start from bank 0.
- Asynchronous irst pulse mid-cycle during OWN -> outputs clear immediately without a clock edge, and no gnt pulse appears until a req after release.
